// File: rtl/const_immediate_decoder.sv
// const_immediate_decoder: assembles WebAssembly constant immediates
// (f32/f64 little-endian, i32/i64 signed LEB128) from a byte stream.
// Optional feature macro: CONST_DECODER_LENGTH_EN adds the length[3:0]
// output (bytes consumed by the current decode).
module const_immediate_decoder #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned MAX_LEB_BYTES = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  value_valid,
  input  logic                  value_ready,
  output logic                  busy,
  output logic [1:0]            trap
`ifdef CONST_DECODER_LENGTH_EN
  ,
  output logic [3:0]            length
`endif
);

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned SH_W        = 7;
  localparam int unsigned LEB32_BYTES = 5;
  localparam logic [1:0]  TRAP_NONE     = 2'd0;
  localparam logic [1:0]  TRAP_OVERLONG = 2'd1;
  localparam logic [1:0]  TRAP_MODE     = 2'd2;
  localparam logic [DATA_WIDTH-1:0] LOW32_MASK = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      count;

  logic                  accept;
  logic                  start_take;
  logic                  mode_bad;
  logic [SH_W-1:0]       fix_sh;
  logic [SH_W-1:0]       leb_sh;
  logic [SH_W-1:0]       sext_sh;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] ext;
  logic [DATA_WIDTH-1:0] result;
  logic                  leb_end;
  logic                  last_byte;
  logic                  overlong;
  logic [CNT_W-1:0]      leb_limit;
  logic [CNT_W-1:0]      fix_last;

  logic                  byte_ready_d;
  logic                  value_valid_d;
  logic                  busy_d;
  logic [1:0]            trap_d;

  // Handshake qualifiers; mode[1] selects LEB128, mode[0] selects 64-bit kind
  always_comb begin
    accept     = byte_valid && byte_ready;
    start_take = start && ((state == S_IDLE) || (state == S_ERROR));
    mode_bad   = (DATA_WIDTH == 32) && mode[0];
  end

  // Merge the incoming byte into the accumulator and format the final result
  always_comb begin
    fix_sh    = {count, 3'b000};
    leb_sh    = SH_W'(count) * SH_W'(7);
    sext_sh   = leb_sh + SH_W'(7);
    leb_end   = mode_q[1] && !byte_data[7];
    leb_limit = mode_q[0] ? CNT_W'(MAX_LEB_BYTES - 1) : CNT_W'(LEB32_BYTES - 1);
    fix_last  = mode_q[0] ? CNT_W'(7) : CNT_W'(3);
    overlong  = mode_q[1] && byte_data[7] && (count == leb_limit);
    last_byte = mode_q[1] ? leb_end : (count == fix_last);
    if (mode_q[1]) begin
      acc_next = acc | (DATA_WIDTH'(byte_data[6:0]) << leb_sh);
    end else begin
      acc_next = acc | (DATA_WIDTH'(byte_data) << fix_sh);
    end
    ext = acc_next;
    if (leb_end && byte_data[6]) begin
      ext = acc_next | ({DATA_WIDTH{1'b1}} << sext_sh);
    end
    // 32-bit kinds live in the low word; bits past the kind width are dropped
    result = mode_q[0] ? ext : (ext & LOW32_MASK);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_ERROR: begin
        if (start_take) begin
          state_next = mode_bad ? S_ERROR : S_FETCH;
        end
      end
      S_FETCH: begin
        if (accept) begin
          if (overlong) begin
            state_next = S_ERROR;
          end else if (last_byte) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (value_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered status outputs, derived from the next state
  always_comb begin
    byte_ready_d  = (state_next == S_FETCH);
    value_valid_d = (state_next == S_DONE);
    busy_d        = (state_next != S_IDLE);
    trap_d        = trap;
    if (start_take) begin
      trap_d = mode_bad ? TRAP_MODE : TRAP_NONE;
    end else if ((state == S_FETCH) && accept && overlong) begin
      trap_d = TRAP_OVERLONG;
    end
  end

  // Status output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_ready  <= 1'b0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      trap        <= TRAP_NONE;
    end else begin
      byte_ready  <= byte_ready_d;
      value_valid <= value_valid_d;
      busy        <= busy_d;
      trap        <= trap_d;
    end
  end

  // Datapath: mode latch, accumulator, byte count and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 2'b00;
      acc    <= '0;
      count  <= '0;
      value  <= '0;
    end else if (start_take) begin
      mode_q <= mode;
      acc    <= '0;
      count  <= '0;
    end else if ((state == S_FETCH) && accept) begin
      acc   <= acc_next;
      count <= count + CNT_W'(1);
      if (last_byte && !overlong) begin
        value <= result;
      end
    end
  end

`ifdef CONST_DECODER_LENGTH_EN
  // Byte count is held through DONE and ERROR for PC advance
  assign length = count;
`endif

endmodule

// File: doc/const_immediate_decoder.md
Name: const_immediate_decoder

Overview:
- Fetch-side decoder for WebAssembly constant immediates (i32.const, i64.const, f32.const, f64.const).
- Consumes the immediate byte stream from ROM one byte at a time and assembles the operand value for the CPU to push onto the stack.
- Generalises the fixed 8-byte f64 immediate path to selectable modes: fixed little-endian 4 or 8 bytes, and signed LEB128 for 32 or 64 bits.
- Width is parametrised and errors are reported as trap codes.

Parameters:
- DATA_WIDTH, 64, width of the value output; legal values are 32 or 64.
- MAX_LEB_BYTES, 10, maximum LEB128 length accepted in 64-bit mode; 32-bit mode is fixed at 5.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin decode; sampled only in IDLE.
- mode  input  2  immediate kind: 00 f32 (4B LE), 01 f64 (8B LE), 10 i32 (sLEB128), 11 i64 (sLEB128); latched on start.
- byte_data  input  8  immediate byte from ROM.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  decoder accepts a byte this cycle.
- value  output  DATA_WIDTH  decoded operand.
- value_valid  output  1  value is valid; held until value_ready.
- value_ready  input  1  consumer takes value.
- busy  output  1  high in any state other than IDLE.
- trap  output  2  0 none, 1 LEB128 overlong, 2 mode unsupported at this DATA_WIDTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - value, value_valid, byte_ready, busy and trap are all 0.
  - Internal accumulator and byte count are cleared.
  - Reset asserted mid-decode abandons the decode with no output.
- States: IDLE, FETCH, DONE, ERROR.
- IDLE:
  - byte_ready=0.
  - On start=1: latch mode, clear the accumulator, count=0, clear trap, go to FETCH.
  - If DATA_WIDTH=32 and mode is 01 or 11: go to ERROR with trap=2 instead.
- FETCH:
  - byte_ready=1; a byte is accepted when byte_valid&byte_ready.
  - Fixed modes: acc[8*count+:8] <= byte. After byte N (N=4 or 8), go to DONE.
  - LEB modes: acc |= byte[6:0] << 7*count.
  - LEB termination: if byte[7]=0, the byte ends the decode.
    - If byte[6]=1, sign-extend from bit 7*(count+1).
    - Go to DONE.
  - LEB overlong: if byte[7]=1 on the 5th byte (i32) or on byte MAX_LEB_BYTES (i64), go to ERROR with trap=1.
  - Bits shifted past DATA_WIDTH are discarded.
  - No bytes are accepted while byte_valid=0; state is held.
- Result formatting: i32 and f32 results occupy value[31:0]; upper bits are 0 when DATA_WIDTH=64.
- Latency: value_valid rises on the cycle after the final byte is accepted.
- DONE:
  - value_valid=1, byte_ready=0.
  - value is stable until the cycle value_ready=1; then value_valid drops and the state returns to IDLE.
  - value retains its last content.
- ERROR:
  - byte_ready=0, value_valid=0, and trap is held.
  - start=1 clears trap and begins a new decode, same as from IDLE.
- start asserted in FETCH or DONE is ignored.
- Simultaneous value_ready and start in DONE: return to IDLE; the start is not taken.
- busy is 1 in FETCH, DONE and ERROR.

Optional Feature:
- Macro: CONST_DECODER_LENGTH_EN.
- Defined:
  - Adds output port length[3:0], the number of bytes consumed by the current decode, used for PC advance.
  - length is valid while value_valid=1 and also in ERROR, where it holds the count of bytes accepted.
  - length resets to 0.
- Undefined: the port and its counter logic are absent; behaviour is otherwise identical.

Test Plan:
- f64 decode:
  - Stimulus: mode=01, bytes 00 00 00 00 00 00 00 C0 fed back-to-back.
  - Required: value=64'hC000000000000000 and value_valid=1 one cycle after the 8th byte; trap=0.
- i32 negative:
  - Stimulus: mode=10, byte 7F.
  - Required: value=64'h00000000FFFFFFFF after a single byte; length=1 with CONST_DECODER_LENGTH_EN.
- i64 decode:
  - Stimulus: mode=11, bytes E5 8E 26.
  - Required: value=64'h0000000000098765.
  - Also: mode=11, byte 40 -> value=64'hFFFFFFFFFFFFFFC0.
- i32 overlong:
  - Stimulus: mode=10, bytes 80 80 80 80 80.
  - Required: trap=1, byte_ready=0, value_valid never set.
  - Recovery: a following start with mode=00 and bytes 00 00 80 3F -> value=32'h3F800000.
- Backpressure:
  - Stimulus: value_ready held 0 for 3 cycles in DONE, with start pulsed during that window; byte_valid gaps during FETCH.
  - Required: value stays stable, the start pulse is ignored, and the result is unchanged by the gaps.
- Reset and width limits:
  - Stimulus: reset asserted after 3 of 8 f64 bytes.
  - Required: all outputs 0 immediately, state IDLE; a fresh decode of the next immediate completes correctly.
  - Stimulus: DATA_WIDTH=32 instance with mode=01.
  - Required: trap=2 on the cycle after start.
